// File: rtl/rx_frame_ctrl.sv
// Receive-side frame sequencer: start-bit qualification, bit-centre timing,
// shift/load strobes for the datapath, and the ready/overrun/framing flags.
module rx_frame_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_CENTRE = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD,
    BREAK_WAIT
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic          data_ready_reg;
  logic          framing_error_reg;
  logic          overrun_error_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      timer_reg         <= '0;
      bit_cnt_reg       <= '0;
      data_ready_reg    <= 1'b0;
      framing_error_reg <= 1'b0;
      overrun_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          timer_reg <= '0;
          if (!serial_in) state_reg <= START;
        end
        START: begin
          // Re-check the line half a bit in; a high level here was only a glitch.
          if (timer_reg == T_CENTRE) begin
            timer_reg <= '0;
            if (!serial_in) begin
              framing_error_reg <= 1'b0;
              bit_cnt_reg       <= '0;
              state_reg         <= DATA;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DATA: begin
          if (timer_reg == T_LAST) begin
            timer_reg   <= '0;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == CNT_LAST) state_reg <= STOP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        STOP: begin
          if (timer_reg == T_LAST) begin
            timer_reg <= '0;
            if (serial_in) begin
              state_reg <= LOAD;
            end else begin
              framing_error_reg <= 1'b1;
              state_reg         <= BREAK_WAIT;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        LOAD: state_reg <= IDLE;
        // A line held low after a bad stop bit must not start a new frame.
        BREAK_WAIT: if (serial_in) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      // A load always wins over a read landing in the same cycle.
      if (state_reg == LOAD) begin
        data_ready_reg <= 1'b1;
        if (data_ready_reg && !data_read) overrun_error_reg <= 1'b1;
        else if (data_read)               overrun_error_reg <= 1'b0;
      end else if (data_read) begin
        data_ready_reg    <= 1'b0;
        overrun_error_reg <= 1'b0;
      end
    end
  end

  assign shift_enable  = (state_reg == DATA) && (timer_reg == T_LAST);
  assign load_buffer   = (state_reg == LOAD);
  assign busy          = (state_reg != IDLE);
  assign data_ready    = data_ready_reg;
  assign framing_error = framing_error_reg;
  assign overrun_error = overrun_error_reg;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: default instance plus a 5-bit/4-clock
// instance; expected strobe cycles and words are queued as frames are driven.
module tb_rx_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1, data_read = 1'b0;
  logic shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy;
  logic serial_in_s = 1'b1, data_read_s = 1'b0;
  logic shift_enable_s, load_buffer_s, data_ready_s, framing_error_s, overrun_error_s, busy_s;

  int cyc = 0;
  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    int         at;
    logic [7:0] word;
    logic       ov;
  } load_t;

  int    sh_q[$];
  int    sh_q_s[$];
  load_t ld_q[$];
  load_t ld_q_s[$];

  rx_frame_ctrl u_dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .data_read(data_read),
    .shift_enable(shift_enable), .load_buffer(load_buffer), .data_ready(data_ready),
    .framing_error(framing_error), .overrun_error(overrun_error), .busy(busy)
  );

  rx_frame_ctrl #(.DATA_BITS(5), .CLKS_PER_BIT(4)) u_dut_s (
    .clk(clk), .rst(rst), .serial_in(serial_in_s), .data_read(data_read_s),
    .shift_enable(shift_enable_s), .load_buffer(load_buffer_s), .data_ready(data_ready_s),
    .framing_error(framing_error_s), .overrun_error(overrun_error_s), .busy(busy_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) next_cycle();
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) serial_in_s = v;
    else     serial_in   = v;
  endtask

  // Drive one frame and queue the strobes it must produce.
  task automatic send_frame(input bit sel, input logic [7:0] word, input logic stop_val,
                            input logic exp_ov, input bit chk_fe, input bit rd_at_load);
    int c, db, half, e, ld;
    c    = sel ? 4 : 10;
    db   = sel ? 5 : 8;
    half = c / 2;
    next_cycle();
    e  = cyc;
    ld = e + half + (db + 1) * c + 1;
    for (int k = 1; k <= db; k++) begin
      if (sel) sh_q_s.push_back(e + half + k * c);
      else     sh_q.push_back(e + half + k * c);
    end
    if (stop_val) begin
      if (sel) ld_q_s.push_back('{ld, word, exp_ov});
      else     ld_q.push_back('{ld, word, exp_ov});
    end
    set_line(sel, 1'b0);
    for (int i = 0; i < c; i++) begin
      if (chk_fe && i == half)     check_eq("fe_held_to_sample", framing_error, 1);
      if (chk_fe && i == half + 1) check_eq("fe_clear_at_start", framing_error, 0);
      next_cycle();
    end
    for (int b = 0; b < db; b++) begin
      set_line(sel, word[b]);
      repeat (c) next_cycle();
    end
    set_line(sel, stop_val);
    for (int i = 0; i < c; i++) begin
      if (rd_at_load) data_read = (cyc == ld);
      next_cycle();
    end
    data_read = 1'b0;
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    next_cycle();
    data_read = 1'b0;
  endtask

  // Default-instance monitor.
  logic [7:0] word_m = '0;
  bit         dr_pend = 0;
  logic       ov_pend = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dr_pend) begin
        check_eq("data_ready_after_load", data_ready, 1);
        check_eq("overrun_after_load", overrun_error, ov_pend);
        dr_pend = 0;
      end
      if (shift_enable && load_buffer) check_eq("shift_and_load_together", 1, 0);
      if (shift_enable) begin
        if (sh_q.size() == 0) check_eq("shift_unexpected", cyc, 32'hFFFF_FFFF);
        else                  check_eq("shift_cycle", cyc, sh_q.pop_front());
        word_m = {serial_in, word_m[7:1]};
      end
      if (load_buffer) begin
        if (ld_q.size() == 0) begin
          check_eq("load_unexpected", cyc, 32'hFFFF_FFFF);
        end else begin
          load_t x;
          x = ld_q.pop_front();
          check_eq("load_cycle", cyc, x.at);
          check_eq("load_word", word_m, x.word);
          ov_pend = x.ov;
          dr_pend = 1;
        end
      end
    end
  end

  // Small-instance monitor.
  logic [4:0] word_ms = '0;
  bit         dr_pend_s = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dr_pend_s) begin
        check_eq("s_data_ready_after_load", data_ready_s, 1);
        dr_pend_s = 0;
      end
      if (shift_enable_s) begin
        if (sh_q_s.size() == 0) check_eq("s_shift_unexpected", cyc, 32'hFFFF_FFFF);
        else                    check_eq("s_shift_cycle", cyc, sh_q_s.pop_front());
        word_ms = {serial_in_s, word_ms[4:1]};
      end
      if (load_buffer_s) begin
        if (ld_q_s.size() == 0) begin
          check_eq("s_load_unexpected", cyc, 32'hFFFF_FFFF);
        end else begin
          load_t x;
          x = ld_q_s.pop_front();
          check_eq("s_load_cycle", cyc, x.at);
          check_eq("s_load_word", {3'b000, word_ms}, x.word);
          dr_pend_s = 1;
        end
      end
    end
  end

  initial begin
    int e;
    repeat (3) next_cycle();
    rst = 1'b0;
    check_eq("rst_shift", shift_enable, 0);
    check_eq("rst_load", load_buffer, 0);
    check_eq("rst_ready", data_ready, 0);
    check_eq("rst_framing", framing_error, 0);
    check_eq("rst_overrun", overrun_error, 0);
    check_eq("rst_busy", busy, 0);
    repeat (2) next_cycle();

    // Full frame 0xA5.
    send_frame(0, 8'hA5, 1'b1, 1'b0, 0, 0);
    repeat (3) next_cycle();
    check_eq("a5_idle_busy", busy, 0);

    // Glitch: low for three cycles only.
    e = cyc;
    serial_in = 1'b0;
    wait_cyc(e + 1); check_eq("glitch_busy_rise", busy, 1);
    wait_cyc(e + 3); serial_in = 1'b1;
    wait_cyc(e + 5); check_eq("glitch_busy_at_sample", busy, 1);
    wait_cyc(e + 6); check_eq("glitch_busy_fall", busy, 0);
    check_eq("glitch_ready_kept", data_ready, 1);
    check_eq("glitch_framing_kept", framing_error, 0);
    check_eq("glitch_overrun_kept", overrun_error, 0);

    read_pulse();
    check_eq("read_clears_ready", data_ready, 0);

    // Stop bit low, line held low afterwards.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0, 0);
    check_eq("fe_set", framing_error, 1);
    repeat (25) next_cycle();
    check_eq("fe_break_busy", busy, 1);
    check_eq("fe_no_ready", data_ready, 0);
    serial_in = 1'b1;
    repeat (2) next_cycle();
    check_eq("fe_break_exit", busy, 0);
    check_eq("fe_still_set", framing_error, 1);
    send_frame(0, 8'h5A, 1'b1, 1'b0, 1, 0);
    repeat (2) next_cycle();
    read_pulse();

    // Overrun: two frames without reading.
    send_frame(0, 8'h11, 1'b1, 1'b0, 0, 0);
    send_frame(0, 8'h22, 1'b1, 1'b1, 0, 0);
    repeat (2) next_cycle();
    check_eq("ov_ready_held", data_ready, 1);
    check_eq("ov_flag_held", overrun_error, 1);
    read_pulse();
    check_eq("ov_read_ready", data_ready, 0);
    check_eq("ov_read_flag", overrun_error, 0);

    // Set both flags again, then reset mid-DATA.
    send_frame(0, 8'h81, 1'b1, 1'b0, 0, 0);
    send_frame(0, 8'h7E, 1'b1, 1'b1, 0, 0);
    next_cycle();
    e = cyc;
    serial_in = 1'b0;
    sh_q.push_back(e + 15);
    sh_q.push_back(e + 25);
    wait_cyc(e + 10); serial_in = 1'b1;
    wait_cyc(e + 30);
    check_eq("mid_busy", busy, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check_eq("mid_rst_shift", shift_enable, 0);
    check_eq("mid_rst_load", load_buffer, 0);
    check_eq("mid_rst_ready", data_ready, 0);
    check_eq("mid_rst_framing", framing_error, 0);
    check_eq("mid_rst_overrun", overrun_error, 0);
    check_eq("mid_rst_busy", busy, 0);
    repeat (3) next_cycle();

    // Read landing exactly in the second LOAD cycle.
    send_frame(0, 8'h33, 1'b1, 1'b0, 0, 0);
    send_frame(0, 8'h44, 1'b1, 1'b0, 0, 1);
    repeat (3) next_cycle();
    check_eq("coll_ready", data_ready, 1);
    check_eq("coll_overrun", overrun_error, 0);

    // Small instance: 5 data bits, 4 clocks per bit.
    send_frame(1, 8'h15, 1'b1, 1'b0, 0, 0);
    send_frame(1, 8'h0A, 1'b1, 1'b1, 0, 0);
    repeat (3) next_cycle();
    check_eq("s_overrun", overrun_error_s, 1);

    check_eq("shift_q_left", sh_q.size(), 0);
    check_eq("load_q_left", ld_q.size(), 0);
    check_eq("s_shift_q_left", sh_q_s.size(), 0);
    check_eq("s_load_q_left", ld_q_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
